// File: rtl/seq_mul_nxn.sv
// Iterative shift-add WIDTH x WIDTH multiplier: one multiplier bit per clock, start/busy/done handshake.
// Optional `MUL_SIGNED_EN adds an is_signed port for two's-complement operands.
module seq_mul_nxn #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplr,
`ifdef MUL_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_neg;

  logic [WIDTH-1:0]     w_mcand_in;
  logic [WIDTH-1:0]     w_mplr_in;
  logic                 w_neg_in;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_result;

  // Signed mode captures magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
`ifdef MUL_SIGNED_EN
  logic w_mc_neg, w_mp_neg;
  always_comb begin
    w_mc_neg   = is_signed & mcand[WIDTH-1];
    w_mp_neg   = is_signed & mplr[WIDTH-1];
    w_mcand_in = w_mc_neg ? -mcand : mcand;
    w_mplr_in  = w_mp_neg ? -mplr  : mplr;
    w_neg_in   = w_mc_neg ^ w_mp_neg;
  end
`else
  always_comb begin
    w_mcand_in = mcand;
    w_mplr_in  = mplr;
    w_neg_in   = 1'b0;
  end
`endif

  // Upper half accumulates partial sums, lower half holds the not-yet-retired multiplier bits.
  always_comb begin
    w_addend   = r_acc[0] ? r_mcand : '0;
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    w_result   = r_neg ? -w_acc_next : w_acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= w_mcand_in;
            r_acc   <= {{WIDTH{1'b0}}, w_mplr_in};
            r_count <= CW'(WIDTH);
            r_neg   <= w_neg_in;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            prod    <= w_result;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_nxn.sv
// Randomized and directed bench for seq_mul_nxn (WIDTH=8 and WIDTH=16 instances) against an arithmetic model.
module tb_seq_mul_nxn;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, is_signed;
  logic [7:0]  mcand, mplr;
  logic        busy, done;
  logic [15:0] prod;

  logic        start16, is_signed16;
  logic [15:0] mcand16, mplr16;
  logic        busy16, done16;
  logic [31:0] prod16;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  seq_mul_nxn #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplr(mplr),
`ifdef MUL_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done), .prod(prod)
  );

  seq_mul_nxn #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .mcand(mcand16), .mplr(mplr16),
`ifdef MUL_SIGNED_EN
    .is_signed(is_signed16),
`endif
    .busy(busy16), .done(done16), .prod(prod16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer multiply of the operands as interpreted (signed or unsigned), truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg, input int unsigned w);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (sg && a[w-1]) x = x - (longint'(1) << w);
    if (sg && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 64'(p) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sg);
    mcand = a; mplr = b; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mcand = 8'($urandom); mplr = 8'($urandom); is_signed = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp, input bit noise);
    int unsigned lat;
    lat = 0;
    for (int unsigned k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (noise && k == 3) begin start = 1'b1; mcand = 8'hAA; mplr = 8'hAA; end
      if (noise && k == 4) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_prod"}, 64'(prod), exp);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  task automatic hold_check(input string tag, input logic [63:0] exp);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    @(posedge clk); #1;
    check({tag, "_prod_hold"}, 64'(prod), exp);
  endtask

  logic [7:0] sweep_a [4] = '{8'hFF, 8'h03, 8'hAA, 8'h55};
  logic [7:0] sweep_b [4] = '{8'h00, 8'h01, 8'h10, 8'h11};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int unsigned pulses, lat16;

    rst = 1'b1; start = 1'b0; mcand = '0; mplr = '0; is_signed = 1'b0;
    start16 = 1'b0; mcand16 = '0; mplr16 = '0; is_signed16 = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_prod", 64'(prod), 64'd0);

    launch(8'hFF, 8'h11, 1'b0);
    finish_op("ff_x_11", 64'h10EF, 1'b0);
    hold_check("ff_x_11", 64'h10EF);

    foreach (sweep_a[i]) foreach (sweep_b[j]) begin
      launch(sweep_a[i], sweep_b[j], 1'b0);
      finish_op("sweep", ref_mul(32'(sweep_a[i]), 32'(sweep_b[j]), 1'b0, 8), 1'b0);
      hold_check("sweep", ref_mul(32'(sweep_a[i]), 32'(sweep_b[j]), 1'b0, 8));
    end

    // Back-to-back: second start issued in the done cycle, with an ignored start mid-run.
    launch(8'hFF, 8'h11, 1'b0);
    finish_op("b2b_first", 64'h10EF, 1'b0);
    launch(8'h03, 8'h11, 1'b0);
    finish_op("b2b_second", 64'h0033, 1'b1);
    hold_check("b2b_second", 64'h0033);

    for (int unsigned n = 0; n < 20; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      launch(ra, rb, rs);
      finish_op("random", ref_mul(32'(ra), 32'(rb), rs, 8), 1'b0);
    end

`ifdef MUL_SIGNED_EN
    launch(8'hFF, 8'h11, 1'b1);
    finish_op("signed_m1_x_17", 64'hFFEF, 1'b0);
    launch(8'h80, 8'h80, 1'b1);
    finish_op("signed_min_x_min", 64'h4000, 1'b0);
    launch(8'hFF, 8'h11, 1'b0);
    finish_op("signed_off", 64'h10EF, 1'b0);
`endif

    // Abort: reset lands on the third RUN edge.
    launch(8'hFF, 8'hFF, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_prod", 64'(prod), 64'd0);
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (done) pulses++; end
    check("abort_no_done", 64'(pulses), 64'd0);

    mcand16 = 16'hFFFF; mplr16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat16 = 0;
    for (int unsigned k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (done16) begin lat16 = k; break; end
    end
    check("w16_latency", 64'(lat16), 64'd16);
    check("w16_prod", 64'(prod16), 64'hFFFE0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
